// File: rtl/axis_beat_packer.sv
// ============================================================================
// Module   : axis_beat_packer (with merge core copy_into_empty)
// Purpose  : AXI4-Stream beat compactor. Packs LSB-contiguous partial beats
//            into full-width beats; only the last beat of a packet may be
//            partial. Registered output, residual buffer for spilled bytes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Byte-merge primitive: appends the valid bytes of src after the valid bytes
// of dest. Whatever does not fit in dest is returned LSB-aligned as spill.
module copy_into_empty #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic [DATA_WIDTH-1:0] src_data_in,
  input  logic [KEEP_WIDTH-1:0] src_keep_in,
  input  logic [DATA_WIDTH-1:0] dest_data_in,
  input  logic [KEEP_WIDTH-1:0] dest_keep_in,
  output logic [DATA_WIDTH-1:0] dest_data_out,
  output logic [KEEP_WIDTH-1:0] dest_keep_out,
  output logic [DATA_WIDTH-1:0] src_data_out,
  output logic [KEEP_WIDTH-1:0] src_keep_out
);
  localparam int CNT_WIDTH = $clog2(KEEP_WIDTH + 1);

  logic [CNT_WIDTH-1:0]    w_dest_cnt;
  logic [DATA_WIDTH-1:0]   w_src_m;
  logic [DATA_WIDTH-1:0]   w_dst_m;
  logic [2*DATA_WIDTH-1:0] w_cat_data;
  logic [2*KEEP_WIDTH-1:0] w_cat_keep;

  // Count occupied dest bytes and zero every byte that is not enabled.
  always_comb begin
    w_dest_cnt = '0;
    w_src_m    = '0;
    w_dst_m    = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      w_dest_cnt = w_dest_cnt + CNT_WIDTH'(dest_keep_in[i]);
      w_src_m[8*i +: 8] = src_keep_in[i]  ? src_data_in[8*i +: 8]  : 8'h00;
      w_dst_m[8*i +: 8] = dest_keep_in[i] ? dest_data_in[8*i +: 8] : 8'h00;
    end
  end

  // Double-width concatenation: low half is the merged beat, high half spill.
  assign w_cat_data = ({{DATA_WIDTH{1'b0}}, w_src_m} << {w_dest_cnt, 3'b000})
                    | {{DATA_WIDTH{1'b0}}, w_dst_m};
  assign w_cat_keep = ({{KEEP_WIDTH{1'b0}}, src_keep_in} << w_dest_cnt)
                    | {{KEEP_WIDTH{1'b0}}, dest_keep_in};

  assign dest_data_out = w_cat_data[DATA_WIDTH-1:0];
  assign dest_keep_out = w_cat_keep[KEEP_WIDTH-1:0];
  assign src_data_out  = w_cat_data[2*DATA_WIDTH-1:DATA_WIDTH];
  assign src_keep_out  = w_cat_keep[2*KEEP_WIDTH-1:KEEP_WIDTH];
endmodule

module axis_beat_packer #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128
) (
  input  logic                            axis_aclk,
  input  logic                            axis_resetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast
);
  localparam int KEEP_WIDTH = C_AXIS_DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;

  logic [C_AXIS_DATA_WIDTH-1:0]  r_acc_data;
  logic [KEEP_WIDTH-1:0]         r_acc_keep;
  logic [C_AXIS_DATA_WIDTH-1:0]  w_acc_data_nxt;
  logic [KEEP_WIDTH-1:0]         w_acc_keep_nxt;

  logic [C_AXIS_DATA_WIDTH-1:0]  r_out_data;
  logic [KEEP_WIDTH-1:0]         r_out_keep;
  logic [C_AXIS_TUSER_WIDTH-1:0] r_out_user;
  logic                          r_out_valid;
  logic                          r_out_last;

  logic                          r_first;      // next accepted beat starts a packet
  logic                          r_out_first;  // next loaded beat is first of packet
  logic [C_AXIS_TUSER_WIDTH-1:0] r_user_lat;

  logic                          w_out_free;
  logic                          w_accept;
  logic [C_AXIS_DATA_WIDTH-1:0]  w_mdata;
  logic [KEEP_WIDTH-1:0]         w_mkeep;
  logic [C_AXIS_DATA_WIDTH-1:0]  w_sdata;
  logic [KEEP_WIDTH-1:0]         w_skeep;
  logic                          w_full;
  logic                          w_spill_any;

  logic                          w_load;
  logic                          w_load_last;
  logic [C_AXIS_DATA_WIDTH-1:0]  w_load_data;
  logic [KEEP_WIDTH-1:0]         w_load_keep;
  logic [C_AXIS_TUSER_WIDTH-1:0] w_load_user;

  assign w_out_free    = !r_out_valid || m_axis_tready;
  assign s_axis_tready = axis_resetn && w_out_free && (r_state == ST_ACCUM);
  assign w_accept      = s_axis_tvalid && s_axis_tready;

  copy_into_empty #(
    .DATA_WIDTH (C_AXIS_DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH)
  ) u_merge (
    .src_data_in   (s_axis_tdata),
    .src_keep_in   (s_axis_tkeep),
    .dest_data_in  (r_acc_data),
    .dest_keep_in  (r_acc_keep),
    .dest_data_out (w_mdata),
    .dest_keep_out (w_mkeep),
    .src_data_out  (w_sdata),
    .src_keep_out  (w_skeep)
  );

  assign w_full      = &w_mkeep;
  assign w_spill_any = |w_skeep;

  // The packet's first output beat carries the tuser of its first input beat,
  // taken live if that beat is being accepted now, otherwise from the latch.
  assign w_load_user = r_out_first ? (r_first ? s_axis_tuser : r_user_lat)
                                   : '0;

  // Next-state and datapath control: decide output load and accumulator update.
  always_comb begin
    w_state_nxt    = r_state;
    w_load         = 1'b0;
    w_load_last    = 1'b0;
    w_load_data    = w_mdata;
    w_load_keep    = w_mkeep;
    w_acc_data_nxt = r_acc_data;
    w_acc_keep_nxt = r_acc_keep;
    case (r_state)
      ST_ACCUM: begin
        if (w_accept) begin
          if (w_full) begin
            w_load         = 1'b1;
            w_acc_data_nxt = w_sdata;
            w_acc_keep_nxt = w_skeep;
            if (s_axis_tlast && w_spill_any) begin
              // Residual bytes still pending: close the packet next cycle.
              w_state_nxt = ST_FLUSH;
            end else if (s_axis_tlast) begin
              w_load_last = 1'b1;
            end
          end else if (s_axis_tlast) begin
            // Includes keep==0: an empty tlast beat keeps the packet boundary.
            w_load         = 1'b1;
            w_load_last    = 1'b1;
            w_acc_data_nxt = '0;
            w_acc_keep_nxt = '0;
          end else begin
            w_acc_data_nxt = w_mdata;
            w_acc_keep_nxt = w_mkeep;
          end
        end
      end
      ST_FLUSH: begin
        if (w_out_free) begin
          w_load         = 1'b1;
          w_load_last    = 1'b1;
          w_load_data    = r_acc_data;
          w_load_keep    = r_acc_keep;
          w_acc_data_nxt = '0;
          w_acc_keep_nxt = '0;
          w_state_nxt    = ST_ACCUM;
        end
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) r_state <= ST_ACCUM;
    else              r_state <= w_state_nxt;
  end

  // Residual accumulator.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_acc_data <= '0;
      r_acc_keep <= '0;
    end else begin
      r_acc_data <= w_acc_data_nxt;
      r_acc_keep <= w_acc_keep_nxt;
    end
  end

  // Output register: load a new beat, retire an accepted one, else hold.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_user  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_load_data;
      r_out_keep  <= w_load_keep;
      r_out_user  <= w_load_user;
      r_out_last  <= w_load_last;
    end else if (m_axis_tready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Packet-start tracking for tuser on the input and output sides.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_first     <= 1'b1;
      r_out_first <= 1'b1;
      r_user_lat  <= '0;
    end else begin
      if (w_accept) begin
        r_first <= s_axis_tlast;
        if (r_first) r_user_lat <= s_axis_tuser;
      end
      if (w_load) r_out_first <= w_load_last;
    end
  end

  assign m_axis_tdata  = r_out_data;
  assign m_axis_tkeep  = r_out_keep;
  assign m_axis_tuser  = r_out_user;
  assign m_axis_tvalid = r_out_valid;
  assign m_axis_tlast  = r_out_last;
endmodule

`default_nettype wire

// File: doc/axis_beat_packer.md
Name: axis_beat_packer

Overview:
- AXI4-Stream beat compactor in the packet-processor datapath, directly downstream of header-strip/realign stages that emit partial beats.
- Accumulates LSB-contiguous partial beats into full-width beats using the combinational byte-merge primitive (copy_into_empty) as its merge core.
- Re-emits the packet with every beat full except the last.
- Registered output, with a residual buffer for bytes that spill past a full beat.

Parameters:
- C_AXIS_DATA_WIDTH, 256, tdata width in bits (multiple of 8); KEEP_WIDTH = C_AXIS_DATA_WIDTH/8 is derived.
- C_AXIS_TUSER_WIDTH, 128, sideband metadata width.

Ports:
- axis_aclk  in  1  clock.
- axis_resetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  C_AXIS_DATA_WIDTH  input data; byte 0 in bits [7:0].
- s_axis_tkeep  in  KEEP_WIDTH  byte enables; must be LSB-contiguous; may be 0.
- s_axis_tuser  in  C_AXIS_TUSER_WIDTH  metadata; valid on the first beat of a packet.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  last beat of packet.
- m_axis_tdata  out  C_AXIS_DATA_WIDTH  packed data.
- m_axis_tkeep  out  KEEP_WIDTH  packed byte enables; all ones except on the last beat.
- m_axis_tuser  out  C_AXIS_TUSER_WIDTH  metadata on the first output beat; 0 on all other beats.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  last beat of packet.

Behaviour:
- Reset: single clock domain. axis_resetn low asynchronously clears:
  - all m_axis_* outputs to 0;
  - acc_data and acc_keep to 0;
  - first-beat flag to 1;
  - state to ACCUM.
- s_axis_tready is low while axis_resetn is low.
- State:
  - acc_data/acc_keep hold a partial beat, LSB-contiguous, never full at rest.
  - out_* is the registered output beat.
  - out_free = !m_axis_tvalid || m_axis_tready.
- s_axis_tready = out_free && state==ACCUM. It is combinational from m_axis_tready and state only, not from s_axis_tvalid.
- Merge: in = s_axis beat, dest = acc. Outputs are merged (dest_data_out/dest_keep_out) and spill (src_data_out/src_keep_out).
- On input accept (tvalid && tready), in state ACCUM:
  - merged full, tlast=0: load out with merged (tlast=0); acc <= spill.
  - merged full, tlast=1, spill keep==0: load out with merged (tlast=1); acc <= 0.
  - merged full, tlast=1, spill keep!=0: load out with merged (tlast=0); acc <= spill; go to FLUSH.
  - merged not full, tlast=0: acc <= merged; no output load. If out is accepted this cycle, tvalid drops.
  - merged not full, tlast=1: load out with merged (tlast=1), including keep==0 (a zero-byte tlast beat preserves the packet boundary); acc <= 0.
- FLUSH: when out_free, load out with acc (tlast=1); acc <= 0; go to ACCUM. Input is stalled for exactly that cycle or longer.
- tuser:
  - Latched from the first accepted beat after reset or after a tlast beat.
  - Driven on the first output beat of the packet; all later beats carry 0.
  - If the first input beat does not fill a beat, the latched value waits in a register.
- Latency: an output beat appears the cycle after the input beat that completes it. Throughput is one beat per cycle, except one bubble per packet that needs FLUSH.
- Output is held stable while m_axis_tvalid && !m_axis_tready; no data is lost or duplicated.
- Input tkeep that is not LSB-contiguous is an illegal stimulus; behaviour is undefined.
- Reset asserted mid-packet discards the partial packet. The next packet after reset starts clean, with no residual bytes and the first-beat flag set.

Test Plan:
- Full beats: 3 beats, keep=0xFFFFFFFF, tlast on the 3rd, m_tready=1 -> 3 identical output beats, each 1 cycle after its input, tlast on the 3rd, no stall.
- Half beats: 3 beats, keep=0x0000FFFF, bytes 0x00..0x2F, tlast on the 3rd -> out0 keep=0xFFFFFFFF with bytes 0x00..0x1F in order; out1 keep=0x0000FFFF with bytes 0x20..0x2F, tlast=1.
- Spill at tlast: 2 beats, keep=0x00FFFFFF (24 B each), tlast on the 2nd -> out0 full, tlast=0; then FLUSH beat keep=0x0000FFFF, tlast=1; s_tready=0 during the flush cycle.
- Backpressure: m_tready=0 for 5 cycles mid-packet -> m_axis outputs constant, s_tready=0 once out is occupied and acc is not at rest, every byte delivered exactly once.
- tuser: packet of 3 beats, tuser=0x...ABCD on beat 0, 0x1234 on beat 1 -> out0 tuser=0x...ABCD, later beats 0; next packet latches its own first tuser.
- Edge/reset: keep=0 with tlast and acc empty -> a single beat with keep=0, tlast=1. Reset asserted with acc holding 10 bytes -> outputs 0 immediately; a following 32-byte packet is output unaltered.
